// File: rtl/wt_cache_pkg.sv
// Shared data-cache geometry and SHiP predictor definitions.
package wt_cache_pkg;

  localparam int DCACHE_SET_ASSOC    = 4;
  localparam int DCACHE_NUM_WORDS    = 16;
  localparam int DCACHE_CL_IDX_WIDTH = $clog2(DCACHE_NUM_WORDS);

  localparam int SHIP_SIG_WIDTH = 8;
  localparam int SHIP_CTR_WIDTH = 3;

  typedef logic [1:0] rrpv_t;

  localparam rrpv_t RRPV_NEAR    = 2'd0;
  localparam rrpv_t RRPV_LONG    = 2'd2;
  localparam rrpv_t RRPV_DISTANT = 2'd3;

  typedef enum logic [1:0] {
    SHCT_NOP,
    SHCT_INC,
    SHCT_DEC
  } shct_op_e;

endpackage

// File: rtl/wt_dcache_ship_shct.sv
// Signature History Counter Table: saturating counters with one read-modify-write
// update port and a registered lookup port that sees the pre-update value.
module wt_dcache_ship_shct
  import wt_cache_pkg::*;
#(
  parameter int SIG_WIDTH = SHIP_SIG_WIDTH,
  parameter int CTR_WIDTH = SHIP_CTR_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rd_en_i,
  input  logic [SIG_WIDTH-1:0] rd_sig_i,
  output logic                 rd_valid_o,
  output logic [CTR_WIDTH-1:0] rd_ctr_o,
  input  shct_op_e             upd_op_i,
  input  logic [SIG_WIDTH-1:0] upd_sig_i
);

  localparam int                   NUM_ENTRIES = 1 << SIG_WIDTH;
  localparam logic [CTR_WIDTH-1:0] CTR_MAX     = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_ONE     = CTR_WIDTH'(1);

  logic [CTR_WIDTH-1:0] ctr_q [NUM_ENTRIES];
  logic [CTR_WIDTH-1:0] upd_ctr;
  logic [CTR_WIDTH-1:0] upd_ctr_d;
  logic                 rd_valid_q;
  logic [CTR_WIDTH-1:0] rd_ctr_q;

  always_comb begin
    upd_ctr   = ctr_q[upd_sig_i];
    upd_ctr_d = upd_ctr;
    case (upd_op_i)
      SHCT_INC: if (upd_ctr != CTR_MAX) upd_ctr_d = upd_ctr + CTR_ONE;
      SHCT_DEC: if (upd_ctr != '0)      upd_ctr_d = upd_ctr - CTR_ONE;
      default:  upd_ctr_d = upd_ctr;
    endcase
  end

  // Lookup samples ctr_q before this edge's update lands, giving pre-update data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ctr_q[i] <= CTR_ONE;
      end
      rd_valid_q <= 1'b0;
      rd_ctr_q   <= CTR_ONE;
    end else begin
      if (upd_op_i != SHCT_NOP) begin
        ctr_q[upd_sig_i] <= upd_ctr_d;
      end
      if (rd_en_i) begin
        rd_valid_q <= 1'b1;
        rd_ctr_q   <= ctr_q[rd_sig_i];
      end
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_ctr_o   = rd_ctr_q;

endmodule

// File: rtl/wt_dcache_ship_pred.sv
// SHiP insertion predictor: tracks per-line {valid, reused, sig} and trains the
// SHCT on fills (dead victims) and hits, producing an insertion RRPV per lookup.
module wt_dcache_ship_pred
  import wt_cache_pkg::*;
#(
  parameter int SIG_WIDTH = SHIP_SIG_WIDTH,
  parameter int CTR_WIDTH = SHIP_CTR_WIDTH
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic                                pred_req_i,
  input  logic [SIG_WIDTH-1:0]                pred_sig_i,
  output logic                                pred_valid_o,
  output logic [1:0]                          pred_result_o,
  input  logic                                fill_i,
  input  logic [DCACHE_CL_IDX_WIDTH-1:0]      fill_idx_i,
  input  logic [$clog2(DCACHE_SET_ASSOC)-1:0] fill_way_i,
  input  logic [SIG_WIDTH-1:0]                fill_sig_i,
  input  logic                                hit_i,
  input  logic [DCACHE_CL_IDX_WIDTH-1:0]      hit_idx_i,
  input  logic [$clog2(DCACHE_SET_ASSOC)-1:0] hit_way_i,
  output logic                                conflict_o
);

  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

  logic                 valid_q  [DCACHE_NUM_WORDS][DCACHE_SET_ASSOC];
  logic                 reused_q [DCACHE_NUM_WORDS][DCACHE_SET_ASSOC];
  logic [SIG_WIDTH-1:0] sig_q    [DCACHE_NUM_WORDS][DCACHE_SET_ASSOC];

  logic                 fill_act;
  logic                 hit_act;
  logic                 vic_valid;
  logic                 vic_reused;
  logic [SIG_WIDTH-1:0] vic_sig;
  logic                 hit_valid;
  logic [SIG_WIDTH-1:0] hit_sig;
  shct_op_e             upd_op;
  logic [SIG_WIDTH-1:0] upd_sig;
  logic [CTR_WIDTH-1:0] rd_ctr;
  logic                 rd_valid;
  rrpv_t                rrpv;

  // A fill always wins over a same-cycle hit; a flush suppresses both.
  assign fill_act   = fill_i & ~flush_i;
  assign hit_act    = hit_i & ~fill_i & ~flush_i;
  assign conflict_o = fill_i & hit_i & ~flush_i & ~rst_i;

  assign vic_valid  = valid_q[fill_idx_i][fill_way_i];
  assign vic_reused = reused_q[fill_idx_i][fill_way_i];
  assign vic_sig    = sig_q[fill_idx_i][fill_way_i];
  assign hit_valid  = valid_q[hit_idx_i][hit_way_i];
  assign hit_sig    = sig_q[hit_idx_i][hit_way_i];

  always_comb begin
    upd_op  = SHCT_NOP;
    upd_sig = '0;
    if (fill_act && vic_valid && !vic_reused) begin
      upd_op  = SHCT_DEC;
      upd_sig = vic_sig;
    end else if (hit_act && hit_valid) begin
      upd_op  = SHCT_INC;
      upd_sig = hit_sig;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int w = 0; w < DCACHE_NUM_WORDS; w++) begin
        for (int a = 0; a < DCACHE_SET_ASSOC; a++) begin
          valid_q[w][a]  <= 1'b0;
          reused_q[w][a] <= 1'b0;
          sig_q[w][a]    <= '0;
        end
      end
    end else if (flush_i) begin
      for (int w = 0; w < DCACHE_NUM_WORDS; w++) begin
        for (int a = 0; a < DCACHE_SET_ASSOC; a++) begin
          valid_q[w][a]  <= 1'b0;
          reused_q[w][a] <= 1'b0;
        end
      end
    end else if (fill_act) begin
      valid_q[fill_idx_i][fill_way_i]  <= 1'b1;
      reused_q[fill_idx_i][fill_way_i] <= 1'b0;
      sig_q[fill_idx_i][fill_way_i]    <= fill_sig_i;
    end else if (hit_act && hit_valid) begin
      reused_q[hit_idx_i][hit_way_i] <= 1'b1;
    end
  end

  wt_dcache_ship_shct #(
    .SIG_WIDTH (SIG_WIDTH),
    .CTR_WIDTH (CTR_WIDTH)
  ) i_shct (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_en_i    (pred_req_i),
    .rd_sig_i   (pred_sig_i),
    .rd_valid_o (rd_valid),
    .rd_ctr_o   (rd_ctr),
    .upd_op_i   (upd_op),
    .upd_sig_i  (upd_sig)
  );

  // Counter-to-RRPV mapping is applied to the held counter, so the result stays stable.
  always_comb begin
    rrpv = RRPV_LONG;
    if (rd_ctr == '0) begin
      rrpv = RRPV_DISTANT;
    end else if (rd_ctr == CTR_MAX) begin
      rrpv = RRPV_NEAR;
    end
  end

  assign pred_valid_o  = rd_valid;
  assign pred_result_o = rrpv;

endmodule

// File: tb/tb_wt_dcache_ship_pred.sv
// Randomised scoreboard bench for wt_dcache_ship_pred against a line/counter table model.
module tb_wt_dcache_ship_pred;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       predReq = 1'b0;
  logic [7:0] predSig = '0;
  logic       predValid;
  logic [1:0] predResult;
  logic       fill = 1'b0;
  logic [3:0] fillIdx = '0;
  logic [1:0] fillWay = '0;
  logic [7:0] fillSig = '0;
  logic       hit = 1'b0;
  logic [3:0] hitIdx = '0;
  logic [1:0] hitWay = '0;
  logic       conflict;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       pv;
    logic [1:0] pr;
    logic       cf;
  } exp_t;

  exp_t expQ[$];

  int  mShct [256];
  bit  mValid [16][4];
  bit  mReused [16][4];
  int  mSig [16][4];
  bit  mPredValid = 0;
  int  mPredResult = 2;
  bit  mKnown = 0;

  logic [7:0] sigPool [4] = '{8'h12, 8'h34, 8'h40, 8'h55};

  wt_dcache_ship_pred dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .pred_req_i    (predReq),
    .pred_sig_i    (predSig),
    .pred_valid_o  (predValid),
    .pred_result_o (predResult),
    .fill_i        (fill),
    .fill_idx_i    (fillIdx),
    .fill_way_i    (fillWay),
    .fill_sig_i    (fillSig),
    .hit_i         (hit),
    .hit_idx_i     (hitIdx),
    .hit_way_i     (hitWay),
    .conflict_o    (conflict)
  );

  always #5 clk = ~clk;

  function automatic int expRrpv(int c);
    if (c == 0) return 3;
    if (c == 7) return 0;
    return 2;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Reference behaviour of one clock edge, expressed as table operations.
  task automatic modelStep(input bit r, input bit fl, input bit f, input int fidx, input int fway,
                           input int fsig, input bit h, input int hidx, input int hway,
                           input bit pr, input int psig);
    if (r) begin
      for (int i = 0; i < 256; i++) mShct[i] = 1;
      for (int w = 0; w < 16; w++)
        for (int a = 0; a < 4; a++) begin
          mValid[w][a] = 0; mReused[w][a] = 0; mSig[w][a] = 0;
        end
      mPredValid = 0;
      mPredResult = 2;
      mKnown = 1;
    end else begin
      if (pr) begin
        mPredValid = 1;
        mPredResult = expRrpv(mShct[psig]);
      end
      if (fl) begin
        for (int w = 0; w < 16; w++)
          for (int a = 0; a < 4; a++) begin
            mValid[w][a] = 0; mReused[w][a] = 0;
          end
      end else if (f) begin
        if (mValid[fidx][fway] && !mReused[fidx][fway] && mShct[mSig[fidx][fway]] > 0)
          mShct[mSig[fidx][fway]] -= 1;
        mValid[fidx][fway] = 1;
        mReused[fidx][fway] = 0;
        mSig[fidx][fway] = fsig;
      end else if (h && mValid[hidx][hway]) begin
        if (mShct[mSig[hidx][hway]] < 7) mShct[mSig[hidx][hway]] += 1;
        mReused[hidx][hway] = 1;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic fl, input logic f,
                               input logic [3:0] fidx, input logic [1:0] fway, input logic [7:0] fsig,
                               input logic h, input logic [3:0] hidx, input logic [1:0] hway,
                               input logic pr, input logic [7:0] psig);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; flush = fl; fill = f; fillIdx = fidx; fillWay = fway; fillSig = fsig;
    hit = h; hitIdx = hidx; hitWay = hway; predReq = pr; predSig = psig;
    if (mKnown) begin
      e.pv = mPredValid;
      e.pr = 2'(mPredResult);
      e.cf = !r && !fl && f && h;
      expQ.push_back(e);
    end
    modelStep(r, fl, f, int'(fidx), int'(fway), int'(fsig), h, int'(hidx), int'(hway), pr, int'(psig));
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 4'd0, 2'd0, 8'd0, 0, 4'd0, 2'd0, 0, 8'd0);
  endtask
  task automatic doReset();
    applyStimulus(1, 0, 0, 4'd0, 2'd0, 8'd0, 0, 4'd0, 2'd0, 0, 8'd0);
  endtask
  task automatic doFlush();
    applyStimulus(0, 1, 0, 4'd0, 2'd0, 8'd0, 0, 4'd0, 2'd0, 0, 8'd0);
  endtask
  task automatic doFill(input logic [3:0] idx, input logic [1:0] way, input logic [7:0] sig);
    applyStimulus(0, 0, 1, idx, way, sig, 0, 4'd0, 2'd0, 0, 8'd0);
  endtask
  task automatic doHit(input logic [3:0] idx, input logic [1:0] way);
    applyStimulus(0, 0, 0, 4'd0, 2'd0, 8'd0, 1, idx, way, 0, 8'd0);
  endtask
  task automatic doReq(input logic [7:0] sig);
    applyStimulus(0, 0, 0, 4'd0, 2'd0, 8'd0, 0, 4'd0, 2'd0, 1, sig);
  endtask

  // Monitor: pops the expectation for the current cycle and compares mid-cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput("sb_pred_valid", int'(predValid), int'(e.pv));
      checkOutput("sb_pred_result", int'(predResult), int'(e.pr));
      checkOutput("sb_conflict", int'(conflict), int'(e.cf));
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    doReset();
    doReset();
    idle();
    @(negedge clk);
    checkOutput("reset_pred_valid", int'(predValid), 0);
    checkOutput("reset_pred_result", int'(predResult), 2);
    checkOutput("reset_conflict", int'(conflict), 0);

    doReq(8'h12);
    idle();
    @(negedge clk);
    checkOutput("lookup_after_reset_valid", int'(predValid), 1);
    checkOutput("lookup_after_reset_result", int'(predResult), 2);

    doFill(4'd5, 2'd0, 8'h12);
    doFill(4'd5, 2'd0, 8'h34);
    doReq(8'h12);
    idle();
    @(negedge clk);
    checkOutput("fill_decrement_result", int'(predResult), 3);

    doFill(4'd3, 2'd2, 8'h40);
    repeat (8) doHit(4'd3, 2'd2);
    doReq(8'h40);
    idle();
    @(negedge clk);
    checkOutput("hit_saturation_result", int'(predResult), 0);

    applyStimulus(0, 0, 1, 4'd1, 2'd1, 8'h55, 1, 4'd1, 2'd1, 0, 8'd0);
    @(negedge clk);
    checkOutput("conflict_pulse", int'(conflict), 1);
    idle();
    @(negedge clk);
    checkOutput("conflict_cleared", int'(conflict), 0);
    doReq(8'h55);
    idle();
    @(negedge clk);
    checkOutput("conflict_no_increment", int'(predResult), 2);
    doFill(4'd1, 2'd1, 8'h66);
    doReq(8'h55);
    idle();
    @(negedge clk);
    checkOutput("conflict_line_unreused", int'(predResult), 3);

    doReset();
    doFill(4'd3, 2'd2, 8'h40);
    doHit(4'd3, 2'd2);
    applyStimulus(0, 0, 0, 4'd0, 2'd0, 8'd0, 1, 4'd3, 2'd2, 1, 8'h40);
    idle();
    @(negedge clk);
    checkOutput("overlap_pre_update", int'(predResult), 2);
    doReq(8'h40);
    idle();
    @(negedge clk);
    checkOutput("overlap_repeat", int'(predResult), 2);
    repeat (3) doHit(4'd3, 2'd2);
    applyStimulus(0, 0, 0, 4'd0, 2'd0, 8'd0, 1, 4'd3, 2'd2, 1, 8'h40);
    idle();
    @(negedge clk);
    checkOutput("overlap_pre_update_six", int'(predResult), 2);
    doReq(8'h40);
    idle();
    @(negedge clk);
    checkOutput("overlap_post_update_seven", int'(predResult), 0);

    doFlush();
    doHit(4'd3, 2'd2);
    doFill(4'd3, 2'd2, 8'h77);
    doReq(8'h40);
    idle();
    @(negedge clk);
    checkOutput("flush_keeps_shct", int'(predResult), 0);
    doReq(8'h40);
    doReset();
    @(negedge clk);
    checkOutput("pre_reset_valid", int'(predValid), 1);
    idle();
    @(negedge clk);
    checkOutput("reset_drops_valid", int'(predValid), 0);
    doReq(8'h40);
    idle();
    @(negedge clk);
    checkOutput("reset_restores_ctr", int'(predResult), 2);

    for (int n = 0; n < 3000; n++) begin
      logic r, fl, f, h, pr;
      logic [3:0] fidx, hidx;
      logic [1:0] fway, hway;
      logic [7:0] fsig, psig;
      r    = ($urandom % 200) == 0;
      fl   = ($urandom % 100) == 0;
      f    = ($urandom % 100) < 30;
      h    = ($urandom % 100) < 45;
      pr   = ($urandom % 100) < 40;
      fidx = 4'($urandom % 4);
      hidx = 4'($urandom % 4);
      fway = 2'($urandom);
      hway = 2'($urandom);
      fsig = (($urandom % 10) == 0) ? 8'($urandom) : sigPool[$urandom % 4];
      psig = (($urandom % 10) == 0) ? 8'($urandom) : sigPool[$urandom % 4];
      applyStimulus(r, fl, f, fidx, fway, fsig, h, hidx, hway, pr, psig);
    end
    idle();
    idle();

    for (int k = 0; k < 10 && expQ.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (expQ.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wt_dcache_ship_pred.md
WT_DCACHE_SHIP_PRED -- requirements
Module: wt_dcache_ship_pred

Interface
REQ-001 SHALL take parameter SIG_WIDTH, default 8, the signature width; the SHCT has 2^SIG_WIDTH entries.
REQ-002 SHALL take parameter CTR_WIDTH, default 3, the width of each saturating SHCT counter.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port flush_i, input, 1 bit: invalidates all per-line metadata.
REQ-006 SHALL have ports pred_req_i (input, 1) and pred_sig_i (input, SIG_WIDTH): the insertion-prediction request and its signature.
REQ-007 SHALL have ports pred_valid_o (output, 1) and pred_result_o (output, 2): the RRPV to insert with, which drives the replacement unit's pred_result_i.
REQ-008 SHALL have port fill_i, input, 1 bit: a line fill is committed this cycle.
REQ-009 SHALL have ports fill_idx_i (input, DCACHE_CL_IDX_WIDTH), fill_way_i (input, $clog2(DCACHE_SET_ASSOC)) and fill_sig_i (input, SIG_WIDTH).
REQ-010 SHALL have ports hit_i (input, 1), hit_idx_i (input, DCACHE_CL_IDX_WIDTH) and hit_way_i (input, $clog2(DCACHE_SET_ASSOC)).
REQ-011 SHALL have port conflict_o, output, 1 bit: the hit was dropped because a fill had priority.

Function
REQ-012 SHALL hold per-line metadata {valid, reused, sig} for DCACHE_NUM_WORDS x DCACHE_SET_ASSOC lines, and one SHCT of CTR_WIDTH-bit counters.
REQ-013 SHALL register a lookup: a request with pred_req_i=1 in cycle N produces pred_valid_o=1 and pred_result_o in cycle N+1.
REQ-014 SHALL hold pred_result_o and pred_valid_o stable until the next pred_req_i.
REQ-015 SHALL map the counter value to an RRPV: ctr==0 gives 3 (distant); ctr==2^CTR_WIDTH-1 gives 0 (near); any other value gives 2.
REQ-016 SHALL update a line on fill as follows: if the victim line is valid with reused=0, decrement SHCT[victim sig] saturating at 0; then write {1, 0, fill_sig_i} to the line.
REQ-017 SHALL update a line on hit as follows: if the line is valid, increment SHCT[line sig] saturating at max and set reused=1; a hit to an invalid line changes nothing.
REQ-018 SHALL perform all SHCT updates as a single-cycle read-modify-write, visible to lookups from the next cycle onward.
REQ-019 SHALL serve a lookup in the same cycle as an update to the same entry with the pre-update value.
REQ-020 SHALL, when fill_i and hit_i are both asserted in one cycle, perform only the fill, drop the hit and pulse conflict_o=1 for that cycle, regardless of index.
REQ-021 SHALL, on flush_i, clear valid and reused for all lines in the next cycle, retain the SHCT contents, and ignore fill and hit in that cycle.
REQ-022 SHALL keep conflict_o=0 in every cycle other than the one described in REQ-020.

Reset
REQ-023 SHALL, while rst_i=1 at a clock edge, set every SHCT counter to 1, clear all line metadata, drive pred_valid_o=0, pred_result_o=2 and conflict_o=0, and discard any in-flight lookup.
REQ-024 SHALL give rst_i priority over flush_i, fill_i, hit_i and pred_req_i.

Structure
REQ-025 SHALL define SHIP_SIG_WIDTH, SHIP_CTR_WIDTH and the rrpv_t (2-bit) typedef in wt_cache_pkg.
REQ-026 SHALL place the SHCT, with its saturating increment, saturating decrement and registered read, in the sub-module wt_dcache_ship_shct.

Verification
REQ-027 SHALL cover reset then lookup: lookup sig 0x12 -> next cycle pred_valid_o=1 and pred_result_o=2 (ctr=1).
REQ-028 SHALL cover fill-driven decrement: fill idx 5 way 0 sig 0x12, then fill idx 5 way 0 sig 0x34 with no hit between -> SHCT[0x12]=0 and a lookup of 0x12 returns 3.
REQ-029 SHALL cover hit saturation: fill idx 3 way 2 sig 0x40, then 8 hits to idx 3 way 2 -> SHCT[0x40]=7 (no wrap) and a lookup returns 0.
REQ-030 SHALL cover simultaneous events: fill idx 1 way 1 plus hit idx 1 way 1 in the same cycle -> conflict_o=1 for one cycle, the line metadata is {1,0,fill_sig_i} and the SHCT shows no increment.
REQ-031 SHALL cover lookup/update overlap: lookup sig 0x40 in the same cycle as a hit that increments it from 2 to 3 -> pred_result_o=2 (pre-update value), and a repeat lookup returns 2 from ctr=3.
REQ-032 SHALL cover flush versus reset: flush after training -> lines invalid, SHCT values kept, a hit produces no update; rst_i in the cycle after a lookup -> pred_valid_o=0 and SHCT[0x40]=1.
